// File: rtl/bcrypt_cmp_config_tx.sv
// bcrypt CMP_CONFIG packet serializer: salt, subtype, iter_count, hash_count,
// comparator words and the 0xCC magic byte, one byte per cycle into a FIFO.
module bcrypt_cmp_config_tx #(
   parameter int NUM_HASHES   = 512,
   parameter int HASH_NUM_MSB = 8,
   parameter int SETTING_MAX  = 19
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  start,
   input  logic                  mode_cmp,
   input  logic [127:0]          salt,
   input  logic [7:0]            subtype,
   input  logic [31:0]           iter_count,
   input  logic [15:0]           hash_count,
   output logic                  hash_rd_en,
   output logic [HASH_NUM_MSB:0] hash_rd_addr,
   input  logic [31:0]           hash_din,
   output logic [7:0]            dout,
   output logic                  wr_en,
   input  logic                  full,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int AW = HASH_NUM_MSB + 1;
   localparam logic [15:0] NH = 16'(NUM_HASHES);
   localparam logic [31:0] MASK = 32'h7FFF_FFFF;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SALT  = 3'd1;
   localparam logic [2:0] S_SUB   = 3'd2;
   localparam logic [2:0] S_ITER  = 3'd3;
   localparam logic [2:0] S_HC0   = 3'd4;
   localparam logic [2:0] S_HC1   = 3'd5;
   localparam logic [2:0] S_CMP   = 3'd6;
   localparam logic [2:0] S_MAGIC = 3'd7;

   logic [2:0]    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [127:0]  salt_q, salt_d;
   logic [7:0]    sub_q, sub_d;
   logic [31:0]   iter_q, iter_d;
   logic [15:0]   hcnt_q, hcnt_d;
   logic [31:0]   word_q, word_d;
   logic [31:0]   buf_q, buf_d;
   logic          pend_q, pend_d;
   logic [15:0]   widx_q, widx_d;
   logic          rd_en_q, rd_en_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic          done_q, done_d;
   logic          error_q, error_d;

   logic          sub_ok, iter_ok, cnt_ok, cfg_ok;
   logic [31:0]   fetched;

   always_comb begin
      sub_ok  = (subtype == 8'h61) || (subtype == 8'h62) ||
                (subtype == 8'h78) || (subtype == 8'h79);
      iter_ok = (iter_count >> (SETTING_MAX + 1)) == 32'd0;
      cnt_ok  = mode_cmp ? (hash_count <= NH) : (hash_count == 16'd0);
      cfg_ok  = sub_ok && iter_ok && cnt_ok;
   end

   assign busy         = (state_q != S_IDLE);
   assign wr_en        = busy & ~full;
   assign hash_rd_en   = rd_en_q;
   assign hash_rd_addr = rd_addr_q;
   assign done         = done_q;
   assign error        = error_q;

   always_comb begin
      dout = 8'h00;
      case (state_q)
         S_SALT:  dout = salt_q[{cnt_q, 3'b000} +: 8];
         S_SUB:   dout = sub_q;
         S_ITER:  dout = iter_q[{cnt_q[1:0], 3'b000} +: 8];
         S_HC0:   dout = hcnt_q[7:0];
         S_HC1:   dout = hcnt_q[15:8];
         S_CMP:   dout = word_q[{cnt_q[1:0], 3'b000} +: 8];
         S_MAGIC: dout = 8'hCC;
         default: dout = 8'h00;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      salt_d    = salt_q;
      sub_d     = sub_q;
      iter_d    = iter_q;
      hcnt_d    = hcnt_q;
      word_d    = word_q;
      widx_d    = widx_q;
      rd_en_d   = 1'b0;
      rd_addr_d = rd_addr_q;
      done_d    = 1'b0;
      error_d   = error_q;
      pend_d    = rd_en_q;
      // RAM data is valid only the cycle after the strobe; keep a copy
      fetched   = pend_q ? hash_din : buf_q;
      buf_d     = fetched;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               salt_d = salt;
               sub_d  = subtype;
               iter_d = iter_count;
               hcnt_d = hash_count;
               if (cfg_ok) begin
                  error_d = 1'b0;
                  state_d = S_SALT;
                  cnt_d   = 4'd0;
                  widx_d  = 16'd0;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         S_SALT: begin
            if (wr_en) begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  state_d = S_SUB;
                  cnt_d   = 4'd0;
               end
            end
         end
         S_SUB: begin
            if (wr_en) state_d = S_ITER;
         end
         S_ITER: begin
            if (wr_en) begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd3) begin
                  state_d = S_HC0;
                  cnt_d   = 4'd0;
                  if (hcnt_q != 16'd0) begin
                     rd_en_d   = 1'b1;
                     rd_addr_d = '0;
                  end
               end
            end
         end
         S_HC0: begin
            if (wr_en) state_d = S_HC1;
         end
         S_HC1: begin
            if (wr_en) begin
               if (hcnt_q == 16'd0) begin
                  state_d = S_MAGIC;
               end else begin
                  state_d = S_CMP;
                  cnt_d   = 4'd0;
                  widx_d  = 16'd0;
                  word_d  = fetched & MASK;
                  if (hcnt_q > 16'd1) begin
                     rd_en_d   = 1'b1;
                     rd_addr_d = AW'(16'd1);
                  end
               end
            end
         end
         S_CMP: begin
            if (wr_en) begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd3) begin
                  cnt_d = 4'd0;
                  if (widx_q + 16'd1 == hcnt_q) begin
                     state_d = S_MAGIC;
                  end else begin
                     widx_d = widx_q + 16'd1;
                     word_d = fetched & MASK;
                     if (widx_q + 16'd2 < hcnt_q) begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = AW'(widx_q + 16'd2);
                     end
                  end
               end
            end
         end
         S_MAGIC: begin
            if (wr_en) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= S_IDLE;
         cnt_q     <= 4'd0;
         salt_q    <= '0;
         sub_q     <= 8'd0;
         iter_q    <= 32'd0;
         hcnt_q    <= 16'd0;
         word_q    <= 32'd0;
         buf_q     <= 32'd0;
         pend_q    <= 1'b0;
         widx_q    <= 16'd0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         salt_q    <= salt_d;
         sub_q     <= sub_d;
         iter_q    <= iter_d;
         hcnt_q    <= hcnt_d;
         word_q    <= word_d;
         buf_q     <= buf_d;
         pend_q    <= pend_d;
         widx_q    <= widx_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

endmodule

// File: tb/tb_bcrypt_cmp_config_tx.sv
// Directed bench for bcrypt_cmp_config_tx: packet bytes, stalls,
// rejects, reset mid-packet and ignored restart.
module tb_bcrypt_cmp_config_tx;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         start = 1'b0;
   logic         mode_cmp = 1'b0;
   logic [127:0] salt = '0;
   logic [7:0]   subtype = 8'h00;
   logic [31:0]  iter_count = 32'd0;
   logic [15:0]  hash_count = 16'd0;
   logic         hash_rd_en;
   logic [8:0]   hash_rd_addr;
   logic [31:0]  hash_din;
   logic [7:0]   dout;
   logic         wr_en;
   logic         full = 1'b0;
   logic         busy;
   logic         done;
   logic         error;

   int compared = 0;
   int mismatched = 0;

   logic [31:0] ram [0:511];
   logic [7:0]  exp1 [32];
   logic [7:0]  exp0 [24];
   logic [7:0]  got [$];
   int done_cyc, unstable, rd_seen, max_addr, extra;

   always #5 CLK = ~CLK;

   always @(posedge CLK or posedge RST)
      if (RST) hash_din <= 32'd0;
      else if (hash_rd_en) hash_din <= ram[hash_rd_addr];

   bcrypt_cmp_config_tx dut (
      .CLK(CLK), .RST(RST), .start(start), .mode_cmp(mode_cmp),
      .salt(salt), .subtype(subtype), .iter_count(iter_count),
      .hash_count(hash_count), .hash_rd_en(hash_rd_en),
      .hash_rd_addr(hash_rd_addr), .hash_din(hash_din), .dout(dout),
      .wr_en(wr_en), .full(full), .busy(busy), .done(done),
      .error(error)
   );

   task automatic set_cfg(input logic mc, input logic [7:0] st,
                          input logic [31:0] it, input logic [15:0] n);
      for (int i = 0; i < 16; i++) salt[8*i +: 8] = 8'(i);
      mode_cmp = mc; subtype = st; iter_count = it; hash_count = n;
   endtask

   task automatic pulse_start();
      @(negedge CLK);
      start = 1'b1;
   endtask

   task automatic collect(input bit tog, input int restart_at,
                          input int maxc);
      logic       pf;
      logic [7:0] pd;
      got.delete();
      done_cyc = 0; unstable = 0; rd_seen = 0; max_addr = 0; extra = 0;
      pf = 1'b0; pd = 8'h00;
      for (int i = 1; i <= maxc; i++) begin
         @(negedge CLK);
         start = (i == restart_at);
         full = tog && (i % 2 == 0);
         #1;
         if (hash_rd_en) begin
            rd_seen++;
            if (int'(hash_rd_addr) > max_addr) max_addr = int'(hash_rd_addr);
         end
         if (pf && dout !== pd) unstable++;
         pf = full && busy;
         pd = dout;
         if (wr_en) got.push_back(dout);
         if (done) begin
            done_cyc = i;
            break;
         end
      end
      start = 1'b0;
      for (int j = 0; j < 5; j++) begin
         @(negedge CLK);
         full = 1'b0;
         #1;
         if (wr_en) extra++;
         if (hash_rd_en) rd_seen++;
      end
   endtask

   task automatic check_pkt32(input string nm);
      compared++;
      if (got.size() !== 32) begin
         mismatched++;
         $display("FAIL %s len: got %0d want 32", nm, got.size());
      end else begin
         for (int i = 0; i < 32; i++) begin
            compared++;
            if (got[i] !== exp1[i]) begin
               mismatched++;
               $display("FAIL %s byte%0d: got %h want %h", nm, i, got[i], exp1[i]);
            end
         end
      end
   endtask

   task automatic test_reset();
      compared++;
      if ({busy, done, error, wr_en, hash_rd_en} !== 5'b0 ||
          hash_rd_addr !== 9'd0 || dout !== 8'd0) begin
         mismatched++;
         $display("FAIL reset: got b%b d%b e%b w%b r%b a%h o%h want all 0",
                  busy, done, error, wr_en, hash_rd_en, hash_rd_addr, dout);
      end
   endtask

   task automatic test_basic();
      set_cfg(1'b1, 8'h62, 32'h20, 16'd2);
      pulse_start();
      collect(1'b0, 0, 100);
      check_pkt32("basic");
      compared++;
      if (done_cyc !== 33) begin
         mismatched++;
         $display("FAIL basic done_cycle: got %0d want 33", done_cyc);
      end
      compared++;
      if (rd_seen !== 2 || max_addr !== 1) begin
         mismatched++;
         $display("FAIL basic reads: got %0d/max %0d want 2/max 1", rd_seen, max_addr);
      end
      compared++;
      if (busy !== 1'b0 || extra !== 0) begin
         mismatched++;
         $display("FAIL basic idle_after: busy %b extra %0d want 0 0", busy, extra);
      end
   endtask

   task automatic test_backpressure();
      set_cfg(1'b1, 8'h62, 32'h20, 16'd2);
      pulse_start();
      collect(1'b1, 0, 200);
      check_pkt32("stall");
      compared++;
      if (unstable !== 0) begin
         mismatched++;
         $display("FAIL stall dout_hold: got %0d changes want 0", unstable);
      end
      compared++;
      if (done_cyc === 0) begin
         mismatched++;
         $display("FAIL stall done: got timeout want pulse");
      end
   endtask

   task automatic test_no_cmp();
      set_cfg(1'b0, 8'h78, 32'h20, 16'd0);
      pulse_start();
      collect(1'b0, 0, 100);
      compared++;
      if (got.size() !== 24) begin
         mismatched++;
         $display("FAIL nocmp len: got %0d want 24", got.size());
      end else begin
         for (int i = 0; i < 24; i++) begin
            compared++;
            if (got[i] !== exp0[i]) begin
               mismatched++;
               $display("FAIL nocmp byte%0d: got %h want %h", i, got[i], exp0[i]);
            end
         end
      end
      compared++;
      if (rd_seen !== 0) begin
         mismatched++;
         $display("FAIL nocmp rd_en: got %0d reads want 0", rd_seen);
      end
      compared++;
      if (done_cyc !== 25) begin
         mismatched++;
         $display("FAIL nocmp done_cycle: got %0d want 25", done_cyc);
      end
   endtask

   task automatic test_reject();
      logic [7:0]  st [3];
      logic [31:0] it [3];
      logic [15:0] hc [3];
      st = '{8'h63, 8'h62, 8'h62};
      it = '{32'h20, 32'h0010_0000, 32'h20};
      hc = '{16'd2, 16'd2, 16'd513};
      for (int k = 0; k < 3; k++) begin
         set_cfg(1'b1, st[k], it[k], hc[k]);
         pulse_start();
         collect(1'b0, 0, 4);
         compared++;
         if (got.size() !== 0 || extra !== 0 || error !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reject%0d: got bytes %0d err %b busy %b want 0 1 0",
                     k, got.size() + extra, error, busy);
         end
      end
      set_cfg(1'b1, 8'h62, 32'h20, 16'd2);
      pulse_start();
      collect(1'b0, 0, 100);
      compared++;
      if (error !== 1'b0) begin
         mismatched++;
         $display("FAIL reject_clear: got error %b want 0", error);
      end
      check_pkt32("after_reject");
   endtask

   task automatic test_rst_mid();
      set_cfg(1'b1, 8'h62, 32'h20, 16'd2);
      pulse_start();
      got.delete();
      for (int i = 0; i < 40 && got.size() < 10; i++) begin
         @(negedge CLK);
         start = 1'b0;
         #1;
         if (wr_en) got.push_back(dout);
      end
      #1 RST = 1'b1;
      #1;
      compared++;
      if (wr_en !== 1'b0 || busy !== 1'b0 || got.size() !== 10) begin
         mismatched++;
         $display("FAIL rst_mid: got wr_en %b busy %b n %0d want 0 0 10",
                  wr_en, busy, got.size());
      end
      @(negedge CLK);
      RST = 1'b0;
      pulse_start();
      collect(1'b0, 0, 100);
      check_pkt32("after_rst");
   endtask

   task automatic test_back_to_back();
      set_cfg(1'b1, 8'h62, 32'h20, 16'd2);
      pulse_start();
      collect(1'b0, 6, 100);
      check_pkt32("restart");
      compared++;
      if (done_cyc !== 33 || extra !== 0) begin
         mismatched++;
         $display("FAIL restart len: got done %0d extra %0d want 33 0", done_cyc, extra);
      end
   endtask

   initial begin
      ram[0] = 32'h8123_4567;
      ram[1] = 32'h7FFF_FFFF;
      for (int i = 0; i < 16; i++) begin
         exp1[i] = 8'(i);
         exp0[i] = 8'(i);
      end
      exp1[16:31] = '{8'h62, 8'h20, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00,
                      8'h67, 8'h45, 8'h23, 8'h01, 8'hFF, 8'hFF, 8'hFF,
                      8'h7F, 8'hCC};
      exp0[16:23] = '{8'h78, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                      8'hCC};
      repeat (2) @(negedge CLK);
      test_reset();
      RST = 1'b0;
      test_basic();
      test_backpressure();
      test_no_cmp();
      test_reject();
      test_rst_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
